// File: rtl/poa_pkg.sv
// Shared types for the proof-of-authority block validator: verdict reason codes
// and the control FSM state encoding.
package poa_pkg;

    typedef enum logic [2:0] {
        RSN_OK         = 3'd0,
        RSN_UNKNOWN    = 3'd1,
        RSN_WRONG_TURN = 3'd2,
        RSN_BAD_HEIGHT = 3'd3,
        RSN_EMPTY      = 3'd4
    } poa_reason_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_RESP  = 2'd2
    } poa_state_e;

endpackage

// File: rtl/poa_next_enabled.sv
// Wrap-around priority finder: first enabled slot strictly after start_slot,
// falling back to start_slot itself when it is the only enabled one.
module poa_next_enabled
    import poa_pkg::*;
#(
    parameter int NUM_VALIDATORS = 4,
    localparam int SLOT_W = $clog2(NUM_VALIDATORS)
) (
    input  logic [NUM_VALIDATORS-1:0] en,
    input  logic [SLOT_W-1:0]         start_slot,
    output logic [SLOT_W-1:0]         next_slot,
    output logic                      any_en
);

    logic [SLOT_W-1:0] idx;

    // Scan from the farthest candidate down so the nearest enabled slot wins.
    always_comb begin
        next_slot = start_slot;
        any_en    = |en;
        idx       = start_slot;
        for (int k = NUM_VALIDATORS; k >= 1; k--) begin
            idx = SLOT_W'((int'(start_slot) + k) % NUM_VALIDATORS);
            if (en[idx]) begin
                next_slot = idx;
            end
        end
    end

endmodule

// File: rtl/poa_authority_rotator.sv
// Proof-of-Authority block validator: runtime authority table, round-robin
// proposer turns with timeout skip, consecutive-height check, valid/ready verdict.
module poa_authority_rotator
    import poa_pkg::*;
#(
    parameter int NUM_VALIDATORS = 4,
    parameter int ID_W           = 32,
    parameter int BLK_W          = 32,
    parameter int TIMEOUT        = 16,
    localparam int SLOT_W        = $clog2(NUM_VALIDATORS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_we,
    input  logic [SLOT_W-1:0] cfg_slot,
    input  logic [ID_W-1:0]   cfg_id,
    input  logic              cfg_en,
    input  logic              blk_valid,
    output logic              blk_ready,
    input  logic [BLK_W-1:0]  blk_id,
    input  logic [ID_W-1:0]   blk_validator,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_accept,
    output logic [2:0]        res_reason,
    output logic [BLK_W-1:0]  res_block_id,
    output logic [SLOT_W-1:0] proposer_slot,
    output logic [BLK_W-1:0]  height,
    output logic              skip_pulse
);

    localparam int CNT_W = $clog2(TIMEOUT);

    poa_state_e                  state, state_nxt;
    logic                        started;
    logic [ID_W-1:0]             tbl_id [NUM_VALIDATORS];
    logic [NUM_VALIDATORS-1:0]   tbl_en;
    logic [CNT_W-1:0]            tmo_cnt;

    logic [BLK_W-1:0]            blk_id_p0;
    logic [ID_W-1:0]             validator_p0;
    logic                        accept_p1;
    poa_reason_e                 reason_p1;
    logic [BLK_W-1:0]            block_id_p1;

    logic                        idle;
    logic                        handshake;
    logic [SLOT_W-1:0]           next_slot;
    logic                        any_en;
    logic                        prop_revoked;
    logic                        skip_fire;
    logic                        match_found;
    logic [SLOT_W-1:0]           match_slot;
    logic [BLK_W-1:0]            height_inc;
    poa_reason_e                 verdict;

    poa_next_enabled #(
        .NUM_VALIDATORS (NUM_VALIDATORS)
    ) u_next (
        .en         (tbl_en),
        .start_slot (proposer_slot),
        .next_slot  (next_slot),
        .any_en     (any_en)
    );

    // blk_ready stays low until the first edge after reset release.
    assign idle         = started && (state == S_IDLE);
    assign blk_ready    = idle;
    assign handshake    = blk_valid && blk_ready;
    assign prop_revoked = any_en && !tbl_en[proposer_slot];
    assign skip_fire    = idle && !handshake && any_en && !prop_revoked
                          && (tmo_cnt == CNT_W'(TIMEOUT - 1));
    assign skip_pulse   = skip_fire;

    assign res_valid    = (state == S_RESP);
    assign res_accept   = accept_p1;
    assign res_reason   = reason_p1;
    assign res_block_id = block_id_p1;
    assign height_inc   = height + BLK_W'(1);

    always_comb begin
        match_found = 1'b0;
        match_slot  = '0;
        for (int i = NUM_VALIDATORS - 1; i >= 0; i--) begin
            if (tbl_en[i] && (tbl_id[i] == validator_p0)) begin
                match_found = 1'b1;
                match_slot  = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        verdict = RSN_OK;
        if (!any_en) begin
            verdict = RSN_EMPTY;
        end else if (!match_found) begin
            verdict = RSN_UNKNOWN;
        end else if (match_slot != proposer_slot) begin
            verdict = RSN_WRONG_TURN;
        end else if (blk_id_p0 != height_inc) begin
            verdict = RSN_BAD_HEIGHT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (handshake) state_nxt = S_CHECK;
            S_CHECK: state_nxt = S_RESP;
            S_RESP:  if (res_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            started       <= 1'b0;
            tbl_en        <= '0;
            for (int i = 0; i < NUM_VALIDATORS; i++) begin
                tbl_id[i] <= '0;
            end
            tmo_cnt       <= '0;
            proposer_slot <= '0;
            height        <= '0;
            blk_id_p0     <= '0;
            validator_p0  <= '0;
            accept_p1     <= 1'b0;
            reason_p1     <= RSN_OK;
            block_id_p1   <= '0;
        end else begin
            started <= 1'b1;

            // Table writes land at this edge, after the S_CHECK verdict has sampled the old table.
            if (cfg_we && (int'(cfg_slot) < NUM_VALIDATORS)) begin
                tbl_id[cfg_slot] <= cfg_id;
                tbl_en[cfg_slot] <= cfg_en;
            end

            // ---- stage p0: capture submission ----
            if (handshake) begin
                blk_id_p0    <= blk_id;
                validator_p0 <= blk_validator;
            end

            // ---- stage p1: register verdict ----
            if (state == S_CHECK) begin
                accept_p1   <= (verdict == RSN_OK);
                reason_p1   <= verdict;
                block_id_p1 <= blk_id_p0;
            end

            if ((state == S_CHECK) && (verdict == RSN_OK)) begin
                height        <= blk_id_p0;
                proposer_slot <= next_slot;
                tmo_cnt       <= '0;
            end else if (idle) begin
                if (!any_en) begin
                    tmo_cnt <= '0;
                end else if (prop_revoked) begin
                    proposer_slot <= next_slot;
                    tmo_cnt       <= '0;
                end else if (handshake) begin
                    tmo_cnt <= '0;
                end else if (skip_fire) begin
                    proposer_slot <= next_slot;
                    tmo_cnt       <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_poa_authority_rotator.sv
// Directed bench for poa_authority_rotator with a rule-level reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_poa_authority_rotator;

    localparam int NV  = 4;
    localparam int IDW = 32;
    localparam int BW  = 4;
    localparam int TO  = 16;
    localparam int SW  = 2;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           cfg_we;
    logic [SW-1:0]  cfg_slot;
    logic [IDW-1:0] cfg_id;
    logic           cfg_en;
    logic           blk_valid;
    logic           blk_ready;
    logic [BW-1:0]  blk_id;
    logic [IDW-1:0] blk_validator;
    logic           res_valid;
    logic           res_ready;
    logic           res_accept;
    logic [2:0]     res_reason;
    logic [BW-1:0]  res_block_id;
    logic [SW-1:0]  proposer_slot;
    logic [BW-1:0]  height;
    logic           skip_pulse;

    int errors = 0;
    int checks = 0;

    poa_authority_rotator #(
        .NUM_VALIDATORS (NV),
        .ID_W           (IDW),
        .BLK_W          (BW),
        .TIMEOUT        (TO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cfg_we        (cfg_we),
        .cfg_slot      (cfg_slot),
        .cfg_id        (cfg_id),
        .cfg_en        (cfg_en),
        .blk_valid     (blk_valid),
        .blk_ready     (blk_ready),
        .blk_id        (blk_id),
        .blk_validator (blk_validator),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_accept    (res_accept),
        .res_reason    (res_reason),
        .res_block_id  (res_block_id),
        .proposer_slot (proposer_slot),
        .height        (height),
        .skip_pulse    (skip_pulse)
    );

    always #5 clk = ~clk;

    function void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Reference model: table, chain height, whose turn, idle cycles in this turn,
    // and where the current submission is (0 waiting, 1 being judged, 2 answered).
    bit             m_started;
    int             m_phase;
    logic [IDW-1:0] m_id [NV];
    bit             m_en [NV];
    int             m_height, m_prop, m_idle, m_blk;
    logic [IDW-1:0] m_val;
    bit             m_acc;
    int             m_rsn, m_rblk;

    function automatic int n_en();
        int c = 0;
        for (int i = 0; i < NV; i++) c += m_en[i];
        return c;
    endfunction

    function automatic int next_after(int s);
        for (int k = 1; k <= NV; k++) begin
            if (m_en[(s + k) % NV]) return (s + k) % NV;
        end
        return s;
    endfunction

    function automatic int judge();
        int hit = -1;
        if (n_en() == 0) return 4;
        for (int i = NV - 1; i >= 0; i--) begin
            if (m_en[i] && m_id[i] == m_val) hit = i;
        end
        if (hit < 0) return 1;
        if (hit != m_prop) return 2;
        if (m_blk != ((m_height + 1) % (1 << BW))) return 3;
        return 0;
    endfunction

    task automatic model_reset();
        m_started = 0; m_phase = 0; m_height = 0; m_prop = 0; m_idle = 0;
        m_blk = 0; m_val = '0; m_acc = 0; m_rsn = 0; m_rblk = 0;
        for (int i = 0; i < NV; i++) begin
            m_id[i] = '0;
            m_en[i] = 0;
        end
    endtask

    task automatic model_step();
        if (!m_started) begin
            m_started = 1;
        end else begin
            case (m_phase)
                0: begin
                    if (n_en() == 0) m_idle = 0;
                    else if (!m_en[m_prop]) begin m_prop = next_after(m_prop); m_idle = 0; end
                    else if (blk_valid) m_idle = 0;
                    else if (m_idle == TO - 1) begin m_prop = next_after(m_prop); m_idle = 0; end
                    else m_idle++;
                    if (blk_valid) begin
                        m_blk = int'(blk_id); m_val = blk_validator; m_phase = 1;
                    end
                end
                1: begin
                    m_rsn  = judge();
                    m_acc  = (m_rsn == 0);
                    m_rblk = m_blk;
                    if (m_acc) begin
                        m_height = m_blk; m_prop = next_after(m_prop); m_idle = 0;
                    end
                    m_phase = 2;
                end
                default: if (res_ready) m_phase = 0;
            endcase
        end
        if (cfg_we) begin
            m_id[cfg_slot] = cfg_id;
            m_en[cfg_slot] = cfg_en;
        end
    endtask

    always @(negedge clk) begin
        bit exp_skip;
        exp_skip = m_started && reset_n && m_phase == 0 && !blk_valid && n_en() > 0
                   && m_en[m_prop] && m_idle == TO - 1;
        chk("blk_ready",     blk_ready,     m_started && m_phase == 0);
        chk("res_valid",     res_valid,     m_phase == 2);
        chk("res_accept",    res_accept,    m_acc);
        chk("res_reason",    res_reason,    m_rsn);
        chk("res_block_id",  res_block_id,  m_rblk);
        chk("proposer_slot", proposer_slot, m_prop);
        chk("height",        height,        m_height);
        chk("skip_pulse",    skip_pulse,    exp_skip);
    end

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_step();
        #1;
    endtask

    task automatic send(int b, int v);
        chk("ready_before_send", blk_ready, 1);
        blk_valid     = 1'b1;
        blk_id        = BW'(b);
        blk_validator = IDW'(v);
        tick();
        blk_valid     = 1'b0;
    endtask

    task automatic finish(string nm, int rsn, int rblk);
        tick();
        chk({nm, "_valid"},  res_valid,    1);
        chk({nm, "_reason"}, res_reason,   rsn);
        chk({nm, "_accept"}, res_accept,   rsn == 0);
        chk({nm, "_blk"},    res_block_id, rblk);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic cfg(int slot, int id, bit en);
        cfg_we = 1'b1; cfg_slot = SW'(slot); cfg_id = IDW'(id); cfg_en = en;
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int first_skip;
        int skips;
        reset_n = 1'b0; cfg_we = 1'b0; cfg_slot = '0; cfg_id = '0; cfg_en = 1'b0;
        blk_valid = 1'b0; blk_id = '0; blk_validator = '0; res_ready = 1'b0;
        model_reset();
        repeat (3) tick();
        chk("rst_ready", blk_ready, 0);
        chk("rst_prop", proposer_slot, 0);
        chk("rst_height", height, 0);
        reset_n = 1'b1;
        #1;
        chk("ready_before_edge", blk_ready, 0);
        tick();
        chk("ready_after_edge", blk_ready, 1);

        for (int i = 0; i < NV; i++) cfg(i, i + 1, 1'b1);
        send(1, 1);   finish("ok1", 0, 1);
        chk("ok1_height", height, 1);
        chk("ok1_prop", proposer_slot, 1);

        send(2, 999); finish("unknown", 1, 2);
        send(2, 3);   finish("wrong_turn", 2, 2);
        send(5, 2);   finish("bad_height", 3, 5);
        chk("rej_height", height, 1);
        chk("rej_prop", proposer_slot, 1);

        first_skip = 0;
        for (int i = 1; i <= TO; i++) begin
            if (i > 1) tick();
            if (skip_pulse === 1'b1 && first_skip == 0) first_skip = i;
        end
        chk("skip1_cycle", first_skip, 16);
        tick();
        chk("skip1_prop", proposer_slot, 2);

        cfg(3, 4, 1'b0);
        first_skip = 0;
        for (int i = 3; i <= TO; i++) begin
            tick();
            if (skip_pulse === 1'b1) begin first_skip = i; break; end
        end
        chk("skip2_cycle", first_skip, 16);
        tick();
        chk("skip2_prop", proposer_slot, 0);

        repeat (TO - 1) tick();
        chk("skip_pre_race", skip_pulse, 1);
        blk_valid = 1'b1; blk_id = BW'(2); blk_validator = 1;
        #1;
        chk("skip_race", skip_pulse, 0);
        tick();
        blk_valid = 1'b0;
        finish("race", 0, 2);
        chk("race_height", height, 2);
        chk("race_prop", proposer_slot, 1);

        for (int h = 3; h <= 15; h++) begin
            send(h, m_prop + 1);
            finish("climb", 0, h);
        end
        chk("top_height", height, 15);
        send(0, m_prop + 1); finish("wrap", 0, 0);
        chk("wrap_height", height, 0);

        send(7, m_prop + 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid",  res_valid,    1);
            chk("hold_reason", res_reason,   3);
            chk("hold_accept", res_accept,   0);
            chk("hold_blk",    res_block_id, 7);
            chk("hold_ready",  blk_ready,    0);
            tick();
        end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        chk("hold_height", height, 0);

        send(1, m_prop + 1);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_ready",  blk_ready,     0);
        chk("mid_rst_valid",  res_valid,     0);
        chk("mid_rst_reason", res_reason,    0);
        chk("mid_rst_prop",   proposer_slot, 0);
        chk("mid_rst_height", height,        0);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        send(3, 1); finish("empty_after_reset", 4, 3);

        for (int i = 0; i < NV; i++) cfg(i, i + 1, 1'b1);
        send(1, 1); finish("ok2", 0, 1);
        chk("ok2_prop", proposer_slot, 1);
        cfg(3, 4, 1'b0); cfg(2, 3, 1'b0); cfg(0, 1, 1'b0); cfg(1, 2, 1'b0);
        chk("revoked_prop", proposer_slot, 1);
        send(2, 2); finish("empty", 4, 2);
        skips = 0;
        repeat (3 * TO) begin
            tick();
            if (skip_pulse !== 1'b0) skips++;
        end
        chk("empty_skips", skips, 0);
        chk("empty_prop", proposer_slot, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
